// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter running single-byte transfers for two requesters through a
// register-mapped SPI master. Optional poll timeout enabled by macro SPI_ARB_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | wait for a request, grant by round-robin
// SS_WR    | write slave-select mask of granted requester
// TX_WR    | write the latched transmit byte
// POLL_RD  | read the status register
// POLL_CHK | test receive-ready bit of returned status
// RX_RD    | read the receive-data register
// RX_CAP   | capture the received byte
// DONE     | completion pulse to the granted requester
module spi_xfer_arbiter #(
  parameter logic [2:0]  ADDR_RX  = 3'd0,
  parameter logic [2:0]  ADDR_TX  = 3'd1,
  parameter logic [2:0]  ADDR_ST  = 3'd2,
  parameter logic [2:0]  ADDR_SS  = 3'd4,
  parameter int          RRDY_BIT = 3,
  parameter logic [7:0]  SS_MASK0 = 8'h01,
  parameter logic [7:0]  SS_MASK1 = 8'h02,
  parameter logic [15:0] TIMEOUT  = 16'd1000
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic [1:0] I_REQ,
  input  logic [7:0] I_TXDATA0,
  input  logic [7:0] I_TXDATA1,
  output logic [1:0] O_DONE,
  output logic [7:0] O_RXDATA,
  output logic       O_ERR,
  output logic       O_BUSY,
  output logic       O_TX_EN,
  output logic [2:0] O_WADDR,
  output logic [7:0] O_WDATA,
  output logic       O_RX_EN,
  output logic [2:0] O_RADDR,
  input  logic [7:0] I_RDATA
);

  typedef enum logic [2:0] {
    IDLE, SS_WR, TX_WR, POLL_RD, POLL_CHK, RX_RD, RX_CAP, DONE
  } state_t;

  state_t     state, state_nxt;
  logic       gnt, gnt_nxt, gnt_pick;
  logic [7:0] tx_byte, tx_byte_nxt;
  logic       rr_ptr;
  logic       idle_hold;
  logic       timeout_hit;
  logic       miss_last;

  // rr_ptr names the requester that wins when both are asking
  assign gnt_pick = (I_REQ == 2'b11) ? rr_ptr : I_REQ[1];
  assign O_BUSY   = (state != IDLE);

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] miss_cnt;

  assign miss_last = ({1'b0, miss_cnt} + 17'd1) >= {1'b0, TIMEOUT};

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      miss_cnt <= '0;
      O_ERR    <= 1'b0;
    end else begin
      O_ERR <= timeout_hit;
      if (state == IDLE)
        miss_cnt <= '0;
      else if ((state == POLL_CHK) && !I_RDATA[RRDY_BIT])
        miss_cnt <= miss_cnt + 16'd1;
    end
  end
`else
  assign miss_last = 1'b0;
  assign O_ERR     = 1'b0;
`endif

  always_ff @(posedge I_CLK) begin
    if (I_RESET) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    tx_byte_nxt = tx_byte;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        // idle_hold blocks a grant in the first IDLE cycle after DONE
        if (!idle_hold && (I_REQ != 2'b00)) begin
          gnt_nxt     = gnt_pick;
          tx_byte_nxt = gnt_pick ? I_TXDATA1 : I_TXDATA0;
          state_nxt   = SS_WR;
        end
      end
      SS_WR:   state_nxt = TX_WR;
      TX_WR:   state_nxt = POLL_RD;
      POLL_RD: state_nxt = POLL_CHK;
      POLL_CHK: begin
        if (I_RDATA[RRDY_BIT]) begin
          state_nxt = RX_RD;
        end else if (miss_last) begin
          state_nxt   = DONE;
          timeout_hit = 1'b1;
        end else begin
          state_nxt = POLL_RD;
        end
      end
      RX_RD:   state_nxt = RX_CAP;
      RX_CAP:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so strobes line up with their state
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      gnt       <= 1'b0;
      tx_byte   <= 8'h00;
      rr_ptr    <= 1'b0;
      idle_hold <= 1'b0;
      O_DONE    <= 2'b00;
      O_RXDATA  <= 8'h00;
      O_TX_EN   <= 1'b0;
      O_WADDR   <= 3'd0;
      O_WDATA   <= 8'h00;
      O_RX_EN   <= 1'b0;
      O_RADDR   <= 3'd0;
    end else begin
      gnt       <= gnt_nxt;
      tx_byte   <= tx_byte_nxt;
      idle_hold <= (state == DONE);
      if (state == DONE)
        rr_ptr <= ~gnt;

      O_TX_EN <= (state_nxt == SS_WR) || (state_nxt == TX_WR);
      if (state_nxt == SS_WR) begin
        O_WADDR <= ADDR_SS;
        O_WDATA <= gnt_nxt ? SS_MASK1 : SS_MASK0;
      end else if (state_nxt == TX_WR) begin
        O_WADDR <= ADDR_TX;
        O_WDATA <= tx_byte;
      end

      O_RX_EN <= (state_nxt == POLL_RD) || (state_nxt == RX_RD);
      if (state_nxt == POLL_RD)
        O_RADDR <= ADDR_ST;
      else if (state_nxt == RX_RD)
        O_RADDR <= ADDR_RX;

      if (state == RX_CAP)
        O_RXDATA <= I_RDATA;
      else if (timeout_hit)
        O_RXDATA <= 8'h00;

      O_DONE <= (state_nxt == DONE) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: SPI-master register model, per-transfer
// monitor and a transaction-level reference model (grant order, access counts, latency).
module tb_spi_xfer_arbiter;

  localparam logic [15:0] TMO = 16'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] txd0, txd1, rdata;
  logic [1:0] done;
  logic [7:0] rxdata, wdata;
  logic       err, busy, tx_en, rx_en;
  logic [2:0] waddr, raddr;

  always #5 clk = ~clk;

  spi_xfer_arbiter #(.TIMEOUT(TMO)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_REQ(req), .I_TXDATA0(txd0), .I_TXDATA1(txd1),
    .O_DONE(done), .O_RXDATA(rxdata), .O_ERR(err), .O_BUSY(busy),
    .O_TX_EN(tx_en), .O_WADDR(waddr), .O_WDATA(wdata),
    .O_RX_EN(rx_en), .O_RADDR(raddr), .I_RDATA(rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] mask;
    logic [7:0] txb;
    int         n_wr;
    int         st_rd;
    int         rx_rd;
    int         lat;
    logic [1:0] done;
    logic [7:0] rxd;
    logic       err;
  } xfer_t;

  xfer_t      obs_q[$];
  xfer_t      cur;
  bit         active = 0;
  int         miss_tgt[2];
  logic [7:0] rx_tgt[2];
  int         sidx;
  logic [7:0] sv;

  // Monitor plus SPI master register responder
  always @(negedge clk) begin
    if (rst) begin
      active = 0;
    end else begin
      check_val("strobe_excl", {31'd0, tx_en & rx_en}, 32'd0);
      if (tx_en) begin
        if (waddr == 3'd4) begin
          active    = 1;
          cur.mask  = wdata;
          cur.txb   = 8'h00;
          cur.n_wr  = 0;
          cur.st_rd = 0;
          cur.rx_rd = 0;
          cur.lat   = 0;
          cur.done  = 2'b00;
          cur.rxd   = 8'h00;
          cur.err   = 1'b0;
        end else if (waddr == 3'd1) begin
          cur.txb = wdata;
        end
        cur.n_wr++;
      end
      if (active) cur.lat++;
      if (rx_en) begin
        sidx = (cur.mask == 8'h02) ? 1 : 0;
        if (raddr == 3'd2) begin
          cur.st_rd++;
          sv    = 8'($urandom);
          sv[3] = (cur.st_rd > miss_tgt[sidx]);
          rdata = sv;
        end else if (raddr == 3'd0) begin
          cur.rx_rd++;
          rdata = rx_tgt[sidx];
        end
      end
      if (done != 2'b00) begin
        cur.done = done;
        cur.rxd  = rxdata;
        cur.err  = err;
        obs_q.push_back(cur);
        active = 0;
      end
    end
  end

  int last_srv = 1;

  task automatic run(input logic [1:0] p, input int m0, input int m1,
                     input logic [7:0] t0, input logic [7:0] t1,
                     input logic [7:0] x0, input logic [7:0] x1,
                     input bit drop_early, input bit hold_extra);
    int order[2];
    int n, waited, first_lat, r, m, st, rxr, lat;
    bit tmo;
    logic [1:0] d;
    logic [7:0] exp_rxd;
    xfer_t o;
    txd0 = t0; txd1 = t1; rx_tgt[0] = x0; rx_tgt[1] = x1;
    miss_tgt[0] = m0; miss_tgt[1] = m1;
    if (p == 2'b11) begin
      order[0] = (last_srv == 0) ? 1 : 0;
      order[1] = 1 - order[0];
      n = 2;
    end else begin
      order[0] = p[1] ? 1 : 0;
      order[1] = 0;
      n = 1;
    end
    req = p;
    waited = 0;
    first_lat = -1;
    while (obs_q.size() < n && waited < 400) begin
      @(negedge clk);
      waited++;
      if (drop_early && waited == 3) req = 2'b00;
      if (done != 2'b00) begin
        d = done;
        if (first_lat < 0) first_lat = waited;
        if (hold_extra) begin
          repeat (2) @(negedge clk);
          waited += 2;
        end
        req = req & ~d;
      end
    end
    check_val("n_xfers", obs_q.size(), n);
    repeat (3) @(negedge clk);
    check_val("idle_after", {31'd0, busy}, 32'd0);
    check_val("no_regrant", obs_q.size(), n);
    exp_rxd = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (obs_q.size() == 0) break;
      o = obs_q.pop_front();
      r = order[i];
      m = r ? m1 : m0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo = (m >= int'(TMO));
`else
      tmo = 0;
`endif
      st      = tmo ? int'(TMO) : m + 1;
      rxr     = tmo ? 0 : 1;
      lat     = tmo ? 2 * int'(TMO) + 3 : 2 * m + 7;
      exp_rxd = tmo ? 8'h00 : rx_tgt[r];
      if (i == 0) check_val("req_to_done", first_lat, lat);
      check_val("done_bit", {30'd0, o.done}, r ? 32'd2 : 32'd1);
      check_val("ss_mask", {24'd0, o.mask}, r ? 32'h02 : 32'h01);
      check_val("tx_byte", {24'd0, o.txb}, {24'd0, (r ? t1 : t0)});
      check_val("n_writes", o.n_wr, 2);
      check_val("st_reads", o.st_rd, st);
      check_val("rx_reads", o.rx_rd, rxr);
      check_val("latency", o.lat, lat);
      check_val("rxdata", {24'd0, o.rxd}, {24'd0, exp_rxd});
      check_val("err", {31'd0, o.err}, {31'd0, tmo});
      last_srv = r;
    end
    check_val("rxdata_held", {24'd0, rxdata}, {24'd0, exp_rxd});
    obs_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, {3'd0, done, rxdata, err, busy, tx_en, rx_en, waddr, wdata, raddr}, 32'd0);
  endtask

  initial begin
    int k;
    logic [1:0] p;
    bit de, he;
    rst = 1'b1; req = 2'b00; txd0 = 8'h00; txd1 = 8'h00; rdata = 8'h00;
    miss_tgt[0] = 0; miss_tgt[1] = 0; rx_tgt[0] = 8'h00; rx_tgt[1] = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // both requesting after reset: requester 0 first
    run(2'b11, 1, 2, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0);
    // single request, ready on first poll
    run(2'b01, 0, 0, 8'hA5, 8'h00, 8'h3C, 8'h00, 0, 0);
    // ready withheld for 5 polls
    run(2'b10, 0, 5, 8'h00, 8'h5A, 8'h00, 8'hC3, 0, 0);
    // request dropped mid-transfer, then request held past DONE
    run(2'b01, 1, 0, 8'h7E, 8'h00, 8'h81, 8'h00, 1, 0);
    run(2'b10, 0, 0, 8'h00, 8'h99, 8'h00, 8'h66, 0, 1);

    // reset while in POLL_CHK aborts the transfer
    txd0 = 8'hE1; rx_tgt[0] = 8'h1E; miss_tgt[0] = 2;
    req = 2'b01;
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (rx_en && raddr == 3'd2) break;
    end
    check_val("reach_poll", {31'd0, (k < 60)}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_abort");
    req = 2'b00;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_val("abort_no_done", obs_q.size(), 0);
    obs_q.delete();
    last_srv = 1;
    run(2'b01, 0, 0, 8'h42, 8'h00, 8'h24, 8'h00, 0, 0);

`ifdef SPI_ARB_TIMEOUT_EN
    run(2'b01, 1000, 0, 8'hF0, 8'h00, 8'h0F, 8'h00, 0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      p  = 2'($urandom_range(1, 3));
      de = (p != 2'b11) && ($urandom_range(0, 3) == 0);
      he = (p != 2'b11) && ($urandom_range(0, 3) == 0);
      run(p, $urandom_range(0, 5), $urandom_range(0, 5),
          8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), de, he);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_xfer_arbiter.md
SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_RX, 3'd0, SPI master receive-data register address.
- ADDR_TX, 3'd1, SPI master transmit-data register address.
- ADDR_ST, 3'd2, SPI master status register address.
- ADDR_SS, 3'd4, SPI master slave-select mask register address.
- RRDY_BIT, 3, status bit index meaning "receive byte ready".
- SS_MASK0, 8'h01, slave-select mask written for requester 0.
- SS_MASK1, 8'h02, slave-select mask written for requester 1.
- TIMEOUT, 16'd1000, poll reads before abort (only with SPI_ARB_TIMEOUT_EN).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- I_CLK, in, 1, sole clock; all logic on its rising edge.
- I_RESET, in, 1, synchronous active-high reset.
- I_REQ, in, 2, per-requester transfer request; level, held high until that requester's O_DONE bit pulses.
- I_TXDATA0, in, 8, byte to send for requester 0; stable while I_REQ[0] is high.
- I_TXDATA1, in, 8, byte to send for requester 1; stable while I_REQ[1] is high.
- O_DONE, out, 2, one-cycle completion pulse to the granted requester.
- O_RXDATA, out, 8, received byte; valid in the O_DONE cycle and held until the next O_DONE.
- O_ERR, out, 1, timeout flag; valid in the O_DONE cycle.
- O_BUSY, out, 1, high in every state except IDLE.
- O_TX_EN, out, 1, register write strobe to the SPI master.
- O_WADDR, out, 3, register write address.
- O_WDATA, out, 8, register write data.
- O_RX_EN, out, 1, register read strobe to the SPI master.
- O_RADDR, out, 3, register read address.
- I_RDATA, in, 8, register read data; valid one cycle after the O_RX_EN cycle.

Function
REQ-003 SHALL use the FSM states IDLE, SS_WR, TX_WR, POLL_RD, POLL_CHK, RX_RD, RX_CAP and DONE, with one state per cycle except where a transition below loops.
REQ-004 In IDLE with any I_REQ bit high, the block SHALL grant one requester by round-robin, latch the grant and that requester's TXDATA, and go to SS_WR on the next cycle.
REQ-005 For round-robin, the requester not served last SHALL have priority when both request; the priority pointer SHALL be 0 after reset and SHALL update only in DONE.
REQ-006 In SS_WR, the block SHALL pulse O_TX_EN with O_WADDR=ADDR_SS and O_WDATA=SS_MASKn for the granted requester n, then go to TX_WR.
REQ-007 In TX_WR, the block SHALL pulse O_TX_EN with O_WADDR=ADDR_TX and O_WDATA=latched byte, then go to POLL_RD.
REQ-008 In POLL_RD, the block SHALL pulse O_RX_EN with O_RADDR=ADDR_ST, then go to POLL_CHK.
REQ-009 In POLL_CHK, the block SHALL sample I_RDATA; if I_RDATA[RRDY_BIT]=1 it SHALL go to RX_RD, otherwise it SHALL return to POLL_RD.
REQ-010 In RX_RD, the block SHALL pulse O_RX_EN with O_RADDR=ADDR_RX; in RX_CAP it SHALL register I_RDATA into O_RXDATA.
REQ-011 In DONE, the block SHALL pulse O_DONE[n] for exactly one cycle with O_ERR valid, then return to IDLE.
REQ-012 Strobes SHALL be registered and exclusive: O_TX_EN and O_RX_EN are never high in the same cycle, and each is high for at most one cycle per state visit.
REQ-013 The minimum latency from I_REQ rise in IDLE to O_DONE SHALL be 8 cycles (one poll).
REQ-014 The block SHALL ignore I_REQ changes while busy; a requester that drops I_REQ mid-transfer SHALL still receive its O_DONE pulse.
REQ-015 After DONE, the block SHALL spend at least one IDLE cycle before the next grant, so a requester holding I_REQ for one cycle after O_DONE is not re-granted.
REQ-016 When not strobing, O_WADDR, O_WDATA and O_RADDR SHALL hold their last values.

Reset
REQ-017 When I_RESET=1 at a clock edge, the block SHALL go to IDLE and clear the round-robin pointer, O_DONE, O_ERR, O_BUSY, O_TX_EN, O_RX_EN, O_WADDR, O_WDATA, O_RADDR, O_RXDATA and the timeout counter to 0.
REQ-018 Reset during a transfer SHALL abort it with no O_DONE pulse, and reset SHALL override all other events in the same cycle.

Configuration
REQ-019 With macro SPI_ARB_TIMEOUT_EN defined, the block SHALL count POLL_CHK misses from 0 per transfer.
REQ-020 With SPI_ARB_TIMEOUT_EN defined, reaching TIMEOUT misses SHALL send the FSM to DONE with O_ERR=1 and O_RXDATA=8'h00.
REQ-021 Without SPI_ARB_TIMEOUT_EN, the block SHALL poll indefinitely, have no counter logic, and tie O_ERR to 0.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- I_REQ=01, TXDATA0=A5, status RRDY on the first poll, RX reg=3C: writes (4,01) then (1,A5); O_DONE=01 at cycle 8; O_RXDATA=3C; O_ERR=0.
- I_REQ=11 held, after reset: requester 0 served first, then requester 1 with mask 02; O_DONE order is 01 then 10.
- RRDY withheld for 5 polls: exactly 6 ADDR_ST reads, then one ADDR_RX read, then O_DONE.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT=4, RRDY never set: 4 polls, then O_DONE with O_ERR=1 and O_RXDATA=00.
- I_RESET asserted in POLL_CHK: next cycle all outputs are 0 and there is no O_DONE; a new request completes normally.
